// File: rtl/pc_sequencer.sv
// Program-counter stage: owns the PC, selects the next PC from four sources and
// tracks call/return pairs in a circular return-address stack that audits every jr.
module pc_sequencer #(
  parameter int unsigned        PC_W      = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter int unsigned        RAS_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [1:0]                    pc_sel,
  input  logic                          branch_taken,
  input  logic [15:0]                   imm16,
  input  logic [25:0]                   jaddr,
  input  logic [PC_W-1:0]               rdat,
  input  logic                          is_call,
  input  logic                          ihit,
  input  logic                          stall,
  output logic [PC_W-1:0]               pc,
  output logic [PC_W-1:0]               npc,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_miss,
  output logic                          misalign
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] PC_BRANCH = 2'd0;
  localparam logic [1:0] PC_JRA    = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_NPC    = 2'd3;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miss_q, miss_d;
  logic             mis_q, mis_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];

  logic             adv_s;
  logic             ras_wr_s;
  logic [PC_W-1:0]  npc_s;
  logic [PC_W-1:0]  br_off_s;
  logic [PC_W-1:0]  jump_tgt_s;
  logic [PC_W-1:0]  jra_tgt_s;

  assign adv_s      = ihit & ~stall;
  assign npc_s      = pc_q + PC_W'(32'd4);
  assign br_off_s   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign jump_tgt_s = {npc_s[PC_W-1:28], jaddr, 2'b00};
  assign jra_tgt_s  = {rdat[PC_W-1:2], 2'b00};

  // Next-PC selection and RAS pointer/count bookkeeping; pulses default low.
  always_comb begin
    pc_d     = pc_q;
    tp_d     = tp_q;
    cnt_d    = cnt_q;
    miss_d   = 1'b0;
    mis_d    = 1'b0;
    ras_wr_s = 1'b0;
    if (adv_s) begin
      case (pc_sel)
        PC_BRANCH: pc_d = branch_taken ? (npc_s + br_off_s) : npc_s;
        PC_JUMP:   pc_d = jump_tgt_s;
        PC_JRA: begin
          pc_d  = jra_tgt_s;
          mis_d = (rdat[1:0] != 2'b00);
        end
        PC_NPC:    pc_d = npc_s;
        default:   pc_d = npc_s;
      endcase
      if (is_call && (pc_sel != PC_JRA)) begin
        // A push when full silently overwrites the oldest entry.
        tp_d     = tp_q + PTR_W'(1);
        ras_wr_s = 1'b1;
        cnt_d    = (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : (cnt_q + CNT_W'(1));
      end else if (pc_sel == PC_JRA) begin
        miss_d = (cnt_q == CNT_W'(0)) || (ras_q[tp_q] != jra_tgt_s);
        if (is_call) begin
          ras_wr_s = 1'b1;
          cnt_d    = (cnt_q == CNT_W'(0)) ? CNT_W'(1) : cnt_q;
        end else if (cnt_q != CNT_W'(0)) begin
          tp_d  = tp_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          tp_d  = tp_q;
        end
      end else begin
        tp_d = tp_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State registers: PC, RAS pointer/count and the one-cycle event pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q   <= RESET_PC;
      tp_q   <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tp_q   <= tp_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      mis_q  <= mis_d;
    end
  end

  // RAS storage; the write lands at the post-update top pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (ras_wr_s) begin
      ras_q[tp_d] <= npc_s;
    end
  end

  assign pc        = pc_q;
  assign npc       = npc_s;
  assign ras_count = cnt_q;
  assign ras_miss  = miss_q;
  assign misalign  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, reset corner case,
// and randomized traffic checked against a queue-based return-stack model.
module tb_pc_sequencer;

  localparam int unsigned PC_W     = 32;
  localparam logic [31:0] RST_PC   = 32'h0000_1000;
  localparam int unsigned D        = 4;

  localparam logic [1:0] BR  = 2'd0;
  localparam logic [1:0] JRA = 2'd1;
  localparam logic [1:0] JMP = 2'd2;
  localparam logic [1:0] NPC = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] rdat;
  logic        is_call;
  logic        ihit;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [2:0]  ras_count;
  logic        ras_miss;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_miss;
  logic        m_mis;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(RST_PC), .RAS_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .pc_sel(pc_sel), .branch_taken(branch_taken),
    .imm16(imm16), .jaddr(jaddr), .rdat(rdat), .is_call(is_call),
    .ihit(ihit), .stall(stall), .pc(pc), .npc(npc), .ras_count(ras_count),
    .ras_miss(ras_miss), .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic        bt;
    logic [15:0] imm;
    logic [25:0] ja;
    logic [31:0] rd;
    logic        call;
    logic        hit;
    logic        stl;
    logic [31:0] e_pc;
    int          e_cnt;
    logic        e_miss;
    logic        e_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] sel, logic bt, logic [15:0] imm, logic [25:0] ja,
                              logic [31:0] rd, logic call, logic hit, logic stl,
                              logic [31:0] e_pc, int e_cnt, logic e_miss, logic e_mis);
    vec_t v;
    v.sel = sel; v.bt = bt; v.imm = imm; v.ja = ja; v.rd = rd;
    v.call = call; v.hit = hit; v.stl = stl;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_miss = e_miss; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_PC;
    m_ras.delete();
    m_miss = 1'b0;
    m_mis  = 1'b0;
  endtask

  // Called at posedge+1: drive, advance the model, clock once, compare at posedge+1.
  task automatic step(input logic [1:0] sel, input logic bt, input logic [15:0] imm,
                      input logic [25:0] ja, input logic [31:0] rd, input logic call,
                      input logic hit, input logic stl);
    logic [31:0] nxt;
    logic [31:0] tgt;
    int          off;
    pc_sel = sel; branch_taken = bt; imm16 = imm; jaddr = ja; rdat = rd;
    is_call = call; ihit = hit; stall = stl;
    #1;
    chk("npc", npc, m_pc + 32'd4);
    m_miss = 1'b0;
    m_mis  = 1'b0;
    if (hit && !stl) begin
      nxt = m_pc + 32'd4;
      off = int'($signed(imm)) * 4;
      case (sel)
        BR:      tgt = bt ? nxt + off : nxt;
        JMP:     tgt = {nxt[31:28], ja, 2'b00};
        JRA: begin
          tgt   = rd & 32'hFFFF_FFFC;
          m_mis = (rd % 4) != 0;
        end
        default: tgt = nxt;
      endcase
      if (call && sel != JRA) begin
        m_ras.push_back(nxt);
        if (m_ras.size() > D) void'(m_ras.pop_front());
      end else if (sel == JRA) begin
        m_miss = (m_ras.size() == 0) || (m_ras[$] != tgt);
        if (call) begin
          if (m_ras.size() == 0) m_ras.push_back(nxt);
          else m_ras[m_ras.size()-1] = nxt;
        end else if (m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
      m_pc = tgt;
    end
    @(posedge CLK);
    #1;
    chk("pc", pc, m_pc);
    chk("ras_count", ras_count, m_ras.size());
    chk("ras_miss", ras_miss, m_miss);
    chk("misalign", misalign, m_mis);
  endtask

  initial begin
    logic [31:0] rd;
    pc_sel = NPC; branch_taken = 1'b0; imm16 = 16'h0; jaddr = 26'h0; rdat = 32'h0;
    is_call = 1'b0; ihit = 1'b0; stall = 1'b0;
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_pc", pc, RST_PC);
    chk("reset_cnt", ras_count, 3'd0);
    chk("reset_miss", ras_miss, 1'b0);
    chk("reset_mis", misalign, 1'b0);
    RST = 1'b0;

    //          sel  bt    imm       ja          rd            call  hit   stl   e_pc          cnt miss  mis
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 0, 1'b1, 1'b0));
    tbl.push_back(mk(BR,  1'b1, 16'hFFFF, 26'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0100, 0, 1'b0, 1'b0));
    tbl.push_back(mk(BR,  1'b0, 16'h0010, 26'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0104, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'hF000_0010, 1'b0, 1'b1, 1'b0, 32'hF000_0010, 0, 1'b1, 1'b0));
    tbl.push_back(mk(JMP, 1'b0, 16'h0000, 26'h0000040, 32'h0,   1'b0, 1'b1, 1'b0, 32'hF000_0100, 0, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hF000_0100, 0, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hF000_0100, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 0, 1'b1, 1'b0));
    tbl.push_back(mk(JMP, 1'b0, 16'h0000, 26'h10, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0040, 1, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0024, 1'b0, 1'b1, 1'b0, 32'h0000_0024, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JMP, 1'b0, 16'h0000, 26'h8, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0020, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JMP, 1'b0, 16'h0000, 26'h10, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0000_0040, 1, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0028, 1'b0, 1'b1, 1'b0, 32'h0000_0028, 0, 1'b1, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_002C, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JMP, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0004, 1, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0008, 2, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_000C, 3, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0010, 4, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0014, 4, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0014, 1'b0, 1'b1, 1'b0, 32'h0000_0014, 3, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 2, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_000C, 1'b0, 1'b1, 1'b0, 32'h0000_000C, 1, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0004, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 0, 1'b1, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0004, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JMP, 1'b0, 16'h0000, 26'h20, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0080, 0, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0203, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 1, 1'b1, 1'b1));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0084, 1'b0, 1'b1, 1'b0, 32'h0000_0084, 0, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0088, 1, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_008C, 2, 1'b0, 1'b0));
    tbl.push_back(mk(NPC, 1'b0, 16'h0000, 26'h0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0090, 3, 1'b0, 1'b0));
    tbl.push_back(mk(JRA, 1'b0, 16'h0000, 26'h0, 32'h0000_0041, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 3, 1'b1, 1'b1));

    foreach (tbl[i]) begin
      step(tbl[i].sel, tbl[i].bt, tbl[i].imm, tbl[i].ja, tbl[i].rd,
           tbl[i].call, tbl[i].hit, tbl[i].stl);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_cnt", i), ras_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_miss", i), ras_miss, tbl[i].e_miss);
      chk($sformatf("tbl%0d_mis", i), misalign, tbl[i].e_mis);
    end

    // Mid-cycle reset with pc=0x40, count=3 and both pulses high: must clear at once.
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_cnt", ras_count, 3'd0);
    chk("midrst_miss", ras_miss, 1'b0);
    chk("midrst_mis", misalign, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();

    for (int n = 0; n < 400; n++) begin
      if (m_ras.size() > 0 && $urandom_range(0, 1) == 1)
        rd = m_ras[$];
      else
        rd = $urandom();
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom()),
           26'($urandom()), rd, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
